// File: rtl/led_activity_if.sv
// ============================================================================
// Module : led_activity_if
// Brief  : Activity strobes and force inputs from the core, LED pin drive out.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface led_activity_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] evt;   // per-channel single-cycle activity strobe
   logic [WIDTH-1:0] frc;   // per-channel steady-on override
   logic [WIDTH-1:0] led;   // registered pin drive, board polarity applied

   modport master (output evt, output frc, input led);
   modport slave  (input evt, input frc, output led);
endinterface

`default_nettype wire

// File: rtl/led_activity_driver.sv
// ============================================================================
// Module : led_activity_driver
// Brief  : Stretches activity strobes into visible ON pulses with an OFF gap.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module led_activity_driver #(
   parameter int WIDTH     = 4,
   parameter int RATE      = 125000,
   parameter int ON_TICKS  = 50,
   parameter int OFF_TICKS = 50,
   parameter bit INVERT    = 1'b1
) (
   input  wire logic       clk,
   input  wire logic       rst,
   led_activity_if.slave   act
);

   localparam int C_PW   = (RATE > 1) ? $clog2(RATE) : 1;
   localparam int C_MAXT = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int C_CW   = $clog2(C_MAXT + 1);

   localparam logic [C_PW-1:0]  C_PRESC_LAST = C_PW'(RATE - 1);
   localparam logic [C_PW-1:0]  C_PRESC_ONE  = C_PW'(1);
   localparam logic [C_CW-1:0]  C_ON_LOAD    = C_CW'(ON_TICKS);
   localparam logic [C_CW-1:0]  C_OFF_LOAD   = C_CW'(OFF_TICKS);
   localparam logic [C_CW-1:0]  C_CNT_ONE    = C_CW'(1);
   localparam logic [WIDTH-1:0] C_LED_DARK   = {WIDTH{INVERT}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } state_t;

   // ---------------------------------------------------------------- prescaler
   logic [C_PW-1:0] presc_q, presc_d;
   logic            tick;

   always_comb begin
      tick    = (presc_q == C_PRESC_LAST);
      presc_d = tick ? '0 : presc_q + C_PRESC_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) presc_q <= '0;
      else     presc_q <= presc_d;
   end

   // --------------------------------------------------------- channel FSMs
   logic [WIDTH-1:0] lit;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      state_t          state_q, state_d;
      logic [C_CW-1:0] cnt_q, cnt_d;
      logic            pend_q, pend_d;

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         pend_d  = pend_q;
         case (state_q)
            ST_IDLE: begin
               pend_d = 1'b0;
               if (act.evt[i]) begin
                  state_d = ST_ON;
                  cnt_d   = C_ON_LOAD;
               end
            end
            ST_ON: begin
               pend_d = pend_q | act.evt[i];
               if (tick && (cnt_q == C_CNT_ONE)) begin
                  if (OFF_TICKS != 0) begin
                     state_d = ST_OFF;
                     cnt_d   = C_OFF_LOAD;
                  end else if (pend_q | act.evt[i]) begin
                     // Restart consumes both the stored and the current event.
                     state_d = ST_ON;
                     cnt_d   = C_ON_LOAD;
                     pend_d  = 1'b0;
                  end else begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                  end
               end else if (tick && (cnt_q != '0)) begin
                  cnt_d = cnt_q - C_CNT_ONE;
               end
            end
            ST_OFF: begin
               pend_d = pend_q | act.evt[i];
               if (tick && (cnt_q == C_CNT_ONE)) begin
                  if (pend_q | act.evt[i]) begin
                     state_d = ST_ON;
                     cnt_d   = C_ON_LOAD;
                     pend_d  = 1'b0;
                  end else begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                  end
               end else if (tick && (cnt_q != '0)) begin
                  cnt_d = cnt_q - C_CNT_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
         end
      end

      // Decoded from next state so the pin lights in the cycle after the event.
      assign lit[i] = (state_d == ST_ON) | act.frc[i];
   end

   // ------------------------------------------------------------- pin drive
   logic [WIDTH-1:0] led_q, led_d;

   always_comb begin
      led_d = lit ^ {WIDTH{INVERT}};
   end

   always_ff @(posedge clk) begin
      if (rst) led_q <= C_LED_DARK;
      else     led_q <= led_d;
   end

   assign act.led = led_q;

endmodule

`default_nettype wire
